enemy_bullet_row: RTL
=====================

// Module: enemy_bullet_row
// PURPOSE
//  Enemy projectile row: shift register carrying enemy shots right-to-left (col WIDTH-1 -> col 0),
//  opposite to player bullets. Accepts fire requests from enemy logic, cancels shots colliding with
//  player bullets, flags hits on reaching col 0, and serialises the row to the VGA write-control
//  block one pixel per clock.
// PARAMETERS
//  WIDTH      118        row length in columns (bit i = column i)
//  TICK_DIV   2_500_000  clk cycles per shift tick (20 Hz at 50 MHz); >=2
//  COOLDOWN   4          ticks after an insertion during which no new fire_req is accepted
//  COLOUR     3'b100     draw colour for an enemy shot (empty = 3'b000)
// PORTS
//  clk            in   1      system clock
//  reset          in   1      synchronous, active-high
//  fire_req       in   1      enemy requests a shot; held until fire_ack
//  fire_col       in   7      column of new shot, valid with fire_req
//  fire_ack       out  1      1-cycle pulse: request accepted
//  player_bullets in   WIDTH  player bullet row (1 = bullet)
//  player_in_row  in   1      player ship occupies this row
//  hit_player     out  1      1-cycle pulse: shot left col 0 while player_in_row
//  cancel         out  1      1-cycle pulse: >=1 shot cancelled by player bullet this tick
//  row_data       out  WIDTH  current enemy row
//  draw_en        in   1      level request to draw row
//  draw_x         out  8      column being drawn
//  draw_colour    out  3      COLOUR or 3'b000
//  draw_valid     out  1      draw_x/draw_colour valid this cycle
//  draw_done      out  1      scan complete; held until draw_en low
// BEHAVIOUR
//  Reset: all outputs 0, row 0, tick counter 0, cooldown 0, no pending shot, draw FSM IDLE.
//  Tick: counter 0..TICK_DIV-1; tick = (count==TICK_DIV-1), counter wraps to 0 same cycle.
//  Fire: when no shot pending, cooldown==0, fire_req=1, fire_col<WIDTH: latch col, pulse fire_ack
//   next cycle. fire_col>=WIDTH: never acked, no state change. Requests while pending/cooling: no ack.
//  On tick, in order, all in one registered update:
//   1) shift: next = {1'b0, row[WIDTH-1:1]}; out_bit = row[0].
//   2) insert: if pending, next[col]=1, pending cleared, cooldown=COOLDOWN.
//   3) cancel: next &= ~player_bullets; cancel=1 if any bit cleared.
//   4) hit_player = out_bit & player_in_row; cooldown decrements if nonzero (not on insert tick).
//  fire_req accepted on a tick cycle inserts on the NEXT tick, never the current one.
//  Shots crossing player bullets between ticks without overlapping are not cancelled.
//  Draw FSM: IDLE -> SCAN when draw_en=1; snapshot row on entry (ticks mid-scan do not tear).
//   SCAN: idx 0..WIDTH-1, one per clk: draw_x=idx, draw_colour=snap[idx]?COLOUR:0, draw_valid=1.
//   First valid the cycle after entry; WIDTH valid cycles total. After idx WIDTH-1 -> DONE.
//   DONE: draw_done=1, draw_valid=0; draw_en=0 -> IDLE (draw_done 0).
//   draw_en low mid-SCAN: abort to IDLE next cycle, draw_valid 0, draw_done never asserted.
//  Reset mid-operation: all state to reset values next cycle; pending shot discarded.
// STRUCTURE
//  Package defenders_pkg: ROW_WIDTH=118, colour constants (BLACK, WHITE, RED), draw FSM state enum.
//  Sub-module tick_divider (parameter DIV; clk, reset -> tick pulse); rest is flat.
// TESTING (bench: TICK_DIV=4, COOLDOWN=2)
//  Reset, fire_req col 117 -> ack pulse; after next tick row_data[117]=1; 117 ticks later bit 0;
//   next tick with player_in_row=1 -> hit_player 1 cycle, row_data=0.
//  Same as above with player_in_row=0 -> no hit_player, shot silently removed.
//  Shot at col 50, player_bullets[49]=1 at next tick -> row_data[49]=0, cancel pulse.
//  fire_req held continuously col 10 -> acks spaced by insert tick + 2 cooldown ticks; fire_col=120 -> no ack.
//  draw_en=1 with row bits {0,5,117} -> 118 valid cycles x=0..117, colour 3'b100 at 0,5,117 only;
//   draw_done held; tick mid-scan does not change output; drop draw_en at x=40 -> abort, no done.
//  Assert reset with shot pending and scan active -> next cycle all outputs 0, FSM IDLE, row 0.

Source files
------------

// File: rtl/defenders_pkg.sv
// rtl/defenders_pkg.sv - shared row width, colours and draw FSM state type
package defenders_pkg;

  localparam int ROW_WIDTH = 118;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;

  typedef enum logic [1:0] {
    DRAW_IDLE,
    DRAW_SCAN,
    DRAW_DONE
  } draw_state_e;

endpackage

// File: rtl/enemy_bullet_row_if.sv
// rtl/enemy_bullet_row_if.sv - enemy fire, collision and draw signals of one enemy bullet row
interface enemy_bullet_row_if import defenders_pkg::*; #(
  parameter int WIDTH = ROW_WIDTH
);

  logic             fire_req;
  logic [6:0]       fire_col;
  logic             fire_ack;
  logic [WIDTH-1:0] player_bullets;
  logic             player_in_row;
  logic             hit_player;
  logic             cancel;
  logic [WIDTH-1:0] row_data;
  logic             draw_en;
  logic [7:0]       draw_x;
  logic [2:0]       draw_colour;
  logic             draw_valid;
  logic             draw_done;

  modport master (
    output fire_req, fire_col, player_bullets, player_in_row, draw_en,
    input  fire_ack, hit_player, cancel, row_data, draw_x, draw_colour, draw_valid, draw_done
  );

  modport slave (
    input  fire_req, fire_col, player_bullets, player_in_row, draw_en,
    output fire_ack, hit_player, cancel, row_data, draw_x, draw_colour, draw_valid, draw_done
  );

endinterface

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider giving a one-cycle tick every DIV clocks
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tick_o = (count_q == CW'(DIV - 1));

  always_comb begin
    count_d = tick_o ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/enemy_bullet_row.sv
// rtl/enemy_bullet_row.sv - enemy shot row moving toward column 0, with fire, cancel, hit and
// a snapshot-based pixel scan for the VGA writer
module enemy_bullet_row import defenders_pkg::*; #(
  parameter int         WIDTH    = ROW_WIDTH,
  parameter int         TICK_DIV = 2_500_000,
  parameter int         COOLDOWN = 4,
  parameter logic [2:0] COLOUR   = RED
) (
  input logic               clk,
  input logic               reset,
  enemy_bullet_row_if.slave bus
);

  localparam int CDW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int IDXW = $clog2(WIDTH);

  logic             tick;
  logic [WIDTH-1:0] row_q, row_d, shifted;
  logic             pending_q, pending_d;
  logic [6:0]       col_q, col_d;
  logic [CDW-1:0]   cool_q, cool_d;
  logic             fire_ack_q, fire_ack_d;
  logic             hit_q, hit_d;
  logic             cancel_q, cancel_d;
  logic             accept;

  draw_state_e      state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             scan;

  tick_divider #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  // A request latched on a tick cycle only reaches the row on the following tick.
  always_comb begin
    row_d      = row_q;
    pending_d  = pending_q;
    col_d      = col_q;
    cool_d     = cool_q;
    fire_ack_d = 1'b0;
    hit_d      = 1'b0;
    cancel_d   = 1'b0;
    shifted    = row_q >> 1;
    accept     = !pending_q && (cool_q == '0) && bus.fire_req && (int'(bus.fire_col) < WIDTH);

    if (tick) begin
      if (pending_q) begin
        shifted[col_q] = 1'b1;
        pending_d      = 1'b0;
        cool_d         = CDW'(COOLDOWN);
      end else if (cool_q != '0) begin
        cool_d = cool_q - 1'b1;
      end
      row_d    = shifted & ~bus.player_bullets;
      cancel_d = |(shifted & bus.player_bullets);
      hit_d    = row_q[0] & bus.player_in_row;
    end

    if (accept) begin
      pending_d  = 1'b1;
      col_d      = bus.fire_col;
      fire_ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q      <= '0;
      pending_q  <= 1'b0;
      col_q      <= '0;
      cool_q     <= '0;
      fire_ack_q <= 1'b0;
      hit_q      <= 1'b0;
      cancel_q   <= 1'b0;
    end else begin
      row_q      <= row_d;
      pending_q  <= pending_d;
      col_q      <= col_d;
      cool_q     <= cool_d;
      fire_ack_q <= fire_ack_d;
      hit_q      <= hit_d;
      cancel_q   <= cancel_d;
    end
  end

  // The scan reads a copy taken on entry so a tick mid-scan cannot tear the image.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      DRAW_IDLE: begin
        if (bus.draw_en) begin
          state_d = DRAW_SCAN;
          idx_d   = '0;
          snap_d  = row_q;
        end
      end
      DRAW_SCAN: begin
        if (!bus.draw_en)                        state_d = DRAW_IDLE;
        else if (idx_q == IDXW'(WIDTH - 1))      state_d = DRAW_DONE;
        else                                     idx_d   = idx_q + 1'b1;
      end
      DRAW_DONE: begin
        if (!bus.draw_en) state_d = DRAW_IDLE;
      end
      default: state_d = DRAW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DRAW_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign scan            = (state_q == DRAW_SCAN);
  assign bus.draw_valid  = scan;
  assign bus.draw_x      = scan ? 8'(idx_q) : 8'd0;
  assign bus.draw_colour = (scan && snap_q[idx_q]) ? COLOUR : BLACK;
  assign bus.draw_done   = (state_q == DRAW_DONE);
  assign bus.row_data    = row_q;
  assign bus.fire_ack    = fire_ack_q;
  assign bus.hit_player  = hit_q;
  assign bus.cancel      = cancel_q;

endmodule
